// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - access-size encodings (size_e)
//   - FSM state enumeration (state_e)
//   - byte-lane mask constants and small lane helpers used by both the
//     sequencer and the combinational lane aligner
// ---------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD     = 2'b10,
    SIZE_WORD_ALT = 2'b11   // behaves exactly like SIZE_WORD
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MERGE,
    WRITE,
    RESP
  } state_e;

  // Byte-enable patterns before they are shifted to the addressed lane.
  localparam logic [3:0] LANE_MASK_BYTE = 4'b0001;
  localparam logic [3:0] LANE_MASK_HALF = 4'b0011;
  localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

  // Both word encodings have bit 1 set.
  function automatic logic is_word(size_e size);
    return size[1];
  endfunction

  // First byte lane touched by the access. Misaligned low bits are dropped:
  // a half uses only addr[1], a word always starts at lane 0.
  function automatic logic [1:0] lane_base(size_e size, logic [1:0] addr_lo);
    logic [1:0] base;
    case (size)
      SIZE_BYTE: base = addr_lo;
      SIZE_HALF: base = {addr_lo[1], 1'b0};
      default:   base = 2'b00;
    endcase
    return base;
  endfunction

  function automatic logic [3:0] lane_mask(size_e size);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = LANE_MASK_BYTE;
      SIZE_HALF: mask = LANE_MASK_HALF;
      default:   mask = LANE_MASK_WORD;
    endcase
    return mask;
  endfunction

  function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) || (is_word(size) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Core-side request/response bundle of the load/store unit.
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_we                : 1 = store, 0 = load
//   req_addr, req_wdata   : byte address, LSB-aligned store data
//   req_size, req_unsigned: access size, zero-extend loads
//   resp_valid            : one-cycle completion pulse
//   resp_rdata, resp_err  : extended load data (0 for stores), misalign abort
// Modports: master = core side, slave = load/store unit.
// ---------------------------------------------------------------------------
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane logic for the load/store unit.
//   rd_word    : word read from memory
//   addr_lo    : low two bits of the byte address
//   size       : access size
//   zero_ext   : 1 = zero-extend loads, 0 = sign-extend
//   wdata      : LSB-aligned store data
//   load_data  : selected lane, extended to 32 bits
//   store_word : rd_word with the addressed lanes replaced by wdata
// Little-endian: byte k of the word occupies bits 8k+7:8k.
// ---------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  size_e       size,
  input  logic        zero_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [1:0]  base;
  logic [4:0]  shift;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] wdata_shifted;
  logic [3:0]  byte_en;

  always_comb begin
    base          = lane_base(size, addr_lo);
    shift         = {base, 3'b000};
    lane_byte     = rd_word[shift +: 8];
    lane_half     = rd_word[{base[1], 4'b0000} +: 16];
    wdata_shifted = wdata << shift;
    byte_en       = lane_mask(size) << base;

    case (size)
      SIZE_BYTE: load_data = zero_ext ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      SIZE_HALF: load_data = zero_ext ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default:   load_data = rd_word;
    endcase
  end

  // Per-lane merge: enabled lanes take the shifted store data, the rest keep
  // the word that was read back.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign store_word[8*gi +: 8] = byte_en[gi] ? wdata_shifted[8*gi +: 8] : rd_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Sequences single load/store requests from the core onto a word-wide memory
// with a combinational read port. Sub-word stores do read-merge-write.
//   CLK, RST_N : clock, asynchronous active-low reset
//   core       : lsu_if.slave request/response port
//   MEM_WE     : one-cycle word write enable
//   MEM_A      : word-aligned byte address (0 when no access is in flight)
//   MEM_WD     : full write word
//   MEM_RD     : combinational read word of MEM_A
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned half/word requests skip memory and answer with
//               resp_err=1 one cycle after acceptance
//   undefined : misaligned low address bits are ignored, resp_err stays 0
// Latency from acceptance to resp_valid: load 2, word store 2,
// byte/half store 3, trapped access 1.
// ---------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  lsu_if.slave        core,
  output logic        MEM_WE,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_WD,
  input  logic [31:0] MEM_RD
);

  state_e      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  size_e       size_reg;
  logic        zero_ext_reg;

  logic        mem_we_reg;
  logic [31:0] mem_a_reg;
  logic [31:0] mem_wd_reg;
  logic        resp_valid_reg;
  logic [31:0] resp_rdata_reg;
  logic        resp_err_reg;

  size_e       req_size;
  logic [31:0] req_addr_aligned;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_size         = size_e'(core.req_size);
  assign req_addr_aligned = {core.req_addr[31:2], 2'b00};

  // Lane logic works on the registered request so it is stable for the
  // whole LOAD/MERGE cycle while MEM_RD is sampled.
  lsu_lane_align u_align (
    .rd_word    (MEM_RD),
    .addr_lo    (addr_reg[1:0]),
    .size       (size_reg),
    .zero_ext   (zero_ext_reg),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      size_reg       <= SIZE_BYTE;
      zero_ext_reg   <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_a_reg      <= '0;
      mem_wd_reg     <= '0;
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
    end else begin
      // Pulsed outputs default low; each state re-asserts them as needed.
      mem_we_reg     <= 1'b0;
      resp_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (core.req_valid) begin
            addr_reg     <= core.req_addr;
            wdata_reg    <= core.req_wdata;
            size_reg     <= req_size;
            zero_ext_reg <= core.req_unsigned;
`ifdef LSU_MISALIGN_TRAP_EN
            if (is_misaligned(req_size, core.req_addr[1:0])) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_rdata_reg <= '0;
              resp_err_reg   <= 1'b1;
            end else
`endif
            if (!core.req_we) begin
              state_reg <= LOAD;
              mem_a_reg <= req_addr_aligned;
            end else if (is_word(req_size)) begin
              // Full-word store needs no read; write in the very next cycle.
              state_reg  <= WRITE;
              mem_a_reg  <= req_addr_aligned;
              mem_we_reg <= 1'b1;
              mem_wd_reg <= core.req_wdata;
            end else begin
              state_reg <= MERGE;
              mem_a_reg <= req_addr_aligned;
            end
          end
        end

        LOAD: begin
          state_reg      <= RESP;
          mem_a_reg      <= '0;
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= load_data;
          resp_err_reg   <= 1'b0;
        end

        MERGE: begin
          // MEM_A stays on the same word for the following write.
          state_reg  <= WRITE;
          mem_we_reg <= 1'b1;
          mem_wd_reg <= store_word;
        end

        WRITE: begin
          state_reg      <= RESP;
          mem_a_reg      <= '0;
          mem_wd_reg     <= '0;
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= '0;
          resp_err_reg   <= 1'b0;
        end

        RESP: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Only decoded from the state register, so it drops to 1 asynchronously
  // with reset as well.
  assign core.req_ready  = (state_reg == IDLE);
  assign core.resp_valid = resp_valid_reg;
  assign core.resp_rdata = resp_rdata_reg;
  // Never set outside the trap path, so it is constant 0 in the default build.
  assign core.resp_err   = resp_err_reg;

  assign MEM_WE = mem_we_reg;
  assign MEM_A  = mem_a_reg;
  assign MEM_WD = mem_wd_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit. A transaction-level model predicts,
// per cycle, the memory accesses and responses each accepted request must
// produce; a negedge process compares the DUT against it every cycle.
// Directed transactions also carry hand-computed literal results.
// Build with +define+LSU_MISALIGN_TRAP_EN to exercise the trap variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int NCYC = 2048;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b1;
  logic        MEM_WE;
  logic [31:0] MEM_A;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;

  lsu_if bus ();

  load_store_unit dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .core   (bus),
    .MEM_WE (MEM_WE),
    .MEM_A  (MEM_A),
    .MEM_WD (MEM_WD),
    .MEM_RD (MEM_RD)
  );

  always #5 CLK = ~CLK;

  // Memory seen by the DUT (256 bytes).
  logic [31:0] dut_mem [0:63];
  assign MEM_RD = dut_mem[MEM_A[7:2]];
  always @(posedge CLK) begin
    if (MEM_WE) dut_mem[MEM_A[7:2]] <= MEM_WD;
  end

  // ---------------- model state ----------------
  logic [31:0] model_mem [0:63];
  int          cyc        = 0;
  int          ready_from = 0;
  bit          exp_we    [0:NCYC-1];
  logic [31:0] exp_a     [0:NCYC-1];
  logic [31:0] exp_wd    [0:NCYC-1];
  bit          exp_resp  [0:NCYC-1];
  bit          exp_err   [0:NCYC-1];
  logic [31:0] exp_rdata [0:NCYC-1];
  logic [31:0] last_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  int          we_count    = 0;
  int          last_we_cyc = -1;
  logic [31:0] last_wd     = '0;
  logic [31:0] last_wa     = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes_of(logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic int offset_of(logic [1:0] size, logic [1:0] addr_lo);
    int a = int'(addr_lo);
    return (size == 2'b00) ? a : (size == 2'b01) ? (a & 2) : 0;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] word, logic [1:0] addr_lo,
                                             logic [1:0] size, bit uns);
    int     n   = nbytes_of(size);
    int     off = offset_of(size, addr_lo);
    longint v   = 0;
    for (int i = 0; i < n; i++)
      v = v | (((longint'(word) >> (8 * (off + i))) & 255) << (8 * i));
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(logic [31:0] old, logic [1:0] addr_lo,
                                              logic [1:0] size, logic [31:0] wdata);
    logic [31:0] w   = old;
    int          n   = nbytes_of(size);
    int          off = offset_of(size, addr_lo);
    for (int i = 0; i < n; i++)
      w[8 * (off + i) +: 8] = wdata[8 * i +: 8];
    return w;
  endfunction

  function automatic bit model_trap(logic [1:0] size, logic [1:0] addr_lo);
    bit mis = ((size == 2'b01) && addr_lo[0]) || ((size[1] == 1'b1) && (addr_lo != 2'b00));
    return mis && TRAP_EN;
  endfunction

  // Schedule everything an accepted request must cause, relative to cycle a.
  task automatic model_accept(input int a);
    logic [31:0] addr = bus.req_addr;
    logic [1:0]  size = bus.req_size;
    logic [31:0] al   = {addr[31:2], 2'b00};
    int          idx  = int'(addr[7:2]);
    if (a + 4 >= NCYC) return;
    if (model_trap(size, addr[1:0])) begin
      exp_resp[a+1] = 1'b1; exp_err[a+1] = 1'b1; exp_rdata[a+1] = '0;
      ready_from = a + 2;
    end else if (!bus.req_we) begin
      exp_a[a+1] = al;
      exp_resp[a+2] = 1'b1; exp_err[a+2] = 1'b0;
      exp_rdata[a+2] = model_load(model_mem[idx], addr[1:0], size, bus.req_unsigned);
      ready_from = a + 3;
    end else if (size[1]) begin
      exp_a[a+1] = al; exp_we[a+1] = 1'b1; exp_wd[a+1] = bus.req_wdata;
      exp_resp[a+2] = 1'b1; exp_err[a+2] = 1'b0; exp_rdata[a+2] = '0;
      ready_from = a + 3;
    end else begin
      exp_a[a+1] = al;
      exp_a[a+2] = al; exp_we[a+2] = 1'b1;
      exp_wd[a+2] = model_store(model_mem[idx], addr[1:0], size, bus.req_wdata);
      exp_resp[a+3] = 1'b1; exp_err[a+3] = 1'b0; exp_rdata[a+3] = '0;
      ready_from = a + 4;
    end
  endtask

  task automatic model_reset();
    for (int i = cyc; i < NCYC; i++) begin
      exp_we[i] = 1'b0; exp_a[i] = '0; exp_wd[i] = '0;
      exp_resp[i] = 1'b0; exp_err[i] = 1'b0; exp_rdata[i] = '0;
    end
    ready_from = cyc;
    last_rdata = '0;
  endtask

  // Model: commit writes due this cycle, accept requests, advance cycle.
  initial begin
    forever begin
      @(posedge CLK);
      if (RST_N) begin
        if (exp_we[cyc]) model_mem[exp_a[cyc][7:2]] = exp_wd[cyc];
        if (bus.req_valid && cyc >= ready_from) model_accept(cyc);
      end
      cyc++;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        check("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
        check("rst_mem_a", MEM_A, 32'd0);
        check("rst_mem_wd", MEM_WD, 32'd0);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        last_rdata = '0;
      end else begin
        check("req_ready", {31'd0, bus.req_ready}, {31'd0, cyc >= ready_from});
        check("mem_we", {31'd0, MEM_WE}, {31'd0, exp_we[cyc]});
        check("mem_a", MEM_A, exp_a[cyc]);
        if (exp_we[cyc]) check("mem_wd", MEM_WD, exp_wd[cyc]);
        check("resp_valid", {31'd0, bus.resp_valid}, {31'd0, exp_resp[cyc]});
        if (exp_resp[cyc]) begin
          check("resp_err", {31'd0, bus.resp_err}, {31'd0, exp_err[cyc]});
          last_rdata = exp_rdata[cyc];
        end
        check("resp_rdata", bus.resp_rdata, last_rdata);
      end
    end
  end

  // Record memory writes for the literal checks.
  initial begin
    forever begin
      @(negedge CLK);
      if (MEM_WE === 1'b1) begin
        we_count++;
        last_we_cyc = cyc;
        last_wd     = MEM_WD;
        last_wa     = MEM_A;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver ----------------
  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input bit uns, input bit hold, output int acc);
    bit done = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    acc = -1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (bus.req_ready === 1'b1) begin
        @(posedge CLK);
        #1;
        acc  = cyc - 1;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int acc, output int lat, output logic [31:0] rdata,
                           output logic err);
    lat = -1; rdata = '0; err = 1'b0;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge CLK);
      if (bus.resp_valid === 1'b1) begin
        lat   = cyc - acc;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
      end
    end
    if (lat < 0) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input string name, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                     input int exp_lat, input logic [31:0] exp_rd, input bit exp_e,
                     output int acc);
    int          lat;
    logic [31:0] rd;
    logic        e;
    issue(we, addr, wdata, size, uns, 1'b0, acc);
    wait_resp(acc, lat, rd, e);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " rdata"}, rd, exp_rd);
    check({name, " err"}, {31'd0, e}, {31'd0, exp_e});
    $display("txn %-12s addr=%08h wdata=%08h -> rdata=%08h err=%0d latency=%0d",
             name, addr, wdata, rd, e, lat);
  endtask

  initial begin
    int acc, acc1, acc2, acc3, lat, we_before;
    logic [31:0] rd;
    logic        e;

    for (int i = 0; i < 64; i++) begin
      dut_mem[i]   = '0;
      model_mem[i] = '0;
    end
    dut_mem[16] = 32'h8899AABB; model_mem[16] = 32'h8899AABB;  // 0x40
    dut_mem[17] = 32'hCAFEF00D; model_mem[17] = 32'hCAFEF00D;  // 0x44
    dut_mem[32] = 32'h11223344; model_mem[32] = 32'h11223344;  // 0x80

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_size = 2'b00; bus.req_unsigned = 1'b0;

    #1 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    txn("lb 0x41",  1'b0, 32'h41, 32'h0, 2'b00, 1'b0, 2, 32'hFFFFFFAA, 1'b0, acc);
    txn("lbu 0x41", 1'b0, 32'h41, 32'h0, 2'b00, 1'b1, 2, 32'h000000AA, 1'b0, acc);
    txn("lh 0x42",  1'b0, 32'h42, 32'h0, 2'b01, 1'b0, 2, 32'hFFFF8899, 1'b0, acc);
    txn("lhu 0x40", 1'b0, 32'h40, 32'h0, 2'b01, 1'b1, 2, 32'h0000AABB, 1'b0, acc);

    txn("sh 0x42",  1'b1, 32'h42, 32'h1234, 2'b01, 1'b0, 3, 32'h0, 1'b0, acc);
    check("sh wd", last_wd, 32'h1234AABB);
    check("sh addr", last_wa, 32'h40);
    check("sh we cycle", 32'(last_we_cyc - acc), 32'd2);
    txn("lw 0x40",  1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 2, 32'h1234AABB, 1'b0, acc);

    we_before = we_count;
    txn("sw 0x80",  1'b1, 32'h80, 32'hDEADBEEF, 2'b10, 1'b0, 2, 32'h0, 1'b0, acc);
    check("sw wd", last_wd, 32'hDEADBEEF);
    check("sw we cycle", 32'(last_we_cyc - acc), 32'd1);
    check("sw we pulses", 32'(we_count - we_before), 32'd1);

`ifdef LSU_MISALIGN_TRAP_EN
    we_before = we_count;
    txn("lw 0x82",  1'b0, 32'h82, 32'h0, 2'b10, 1'b0, 1, 32'h0, 1'b1, acc);
    txn("sh 0x41",  1'b1, 32'h41, 32'hBEEF, 2'b01, 1'b0, 1, 32'h0, 1'b1, acc);
    check("trap no write", 32'(we_count - we_before), 32'd0);
    txn("lw 0x40",  1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 2, 32'h1234AABB, 1'b0, acc);
`else
    txn("lw 0x82",  1'b0, 32'h82, 32'h0, 2'b10, 1'b0, 2, 32'hDEADBEEF, 1'b0, acc);
    txn("sh 0x41",  1'b1, 32'h41, 32'hBEEF, 2'b01, 1'b0, 3, 32'h0, 1'b0, acc);
    txn("lw 0x40",  1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 2, 32'h1234BEEF, 1'b0, acc);
`endif

    txn("sw11 0x44", 1'b1, 32'h44, 32'h0BADCAFE, 2'b11, 1'b0, 2, 32'h0, 1'b0, acc);
    txn("lb 0x47",   1'b0, 32'h47, 32'h0, 2'b00, 1'b0, 2, 32'h0000000B, 1'b0, acc);
    txn("lh 0x44",   1'b0, 32'h44, 32'h0, 2'b01, 1'b0, 2, 32'hFFFFCAFE, 1'b0, acc);

    // Reset while the sb sits in MERGE: nothing may reach memory or the core.
    we_before = we_count;
    issue(1'b1, 32'h43, 32'h77, 2'b00, 1'b0, 1'b0, acc);
    #2;
    RST_N = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    check("abort no write", 32'(we_count - we_before), 32'd0);
    check("abort ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort mem 0x40", dut_mem[16], TRAP_EN ? 32'h1234AABB : 32'h1234BEEF);
    $display("txn %-12s addr=%08h wdata=%08h -> aborted by reset", "sb 0x43", 32'h43, 32'h77);

    // Back-to-back with req_valid held high across requests.
    issue(1'b0, 32'h80, 32'h0,  2'b10, 1'b0, 1'b1, acc1);
    issue(1'b1, 32'h81, 32'hEE, 2'b00, 1'b0, 1'b1, acc2);
    issue(1'b0, 32'h82, 32'h0,  2'b01, 1'b1, 1'b0, acc3);
    wait_resp(acc3, lat, rd, e);
    check("b2b gap load", 32'(acc2 - acc1), 32'd3);
    check("b2b gap store", 32'(acc3 - acc2), 32'd4);
    check("b2b lhu rdata", rd, 32'h0000DEAD);
    check("b2b lhu latency", 32'(lat), 32'd2);
    check("b2b mem 0x80", dut_mem[32], 32'hDEADEEEF);
    $display("txn %-12s lw 0x80, sb 0x81, lhu 0x82 -> last rdata=%08h latency=%0d",
             "back-to-back", rd, lat);

    repeat (3) @(negedge CLK);
    for (int i = 0; i < 64; i++) check("final mem", dut_mem[i], model_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports CLK (in, 1, rising-edge clock) and RST_N (in, 1, async active-low reset).
REQ-002 The core-side request port SHALL be: req_valid in 1 (request present); req_ready out 1 (block idle, accepts); req_we in 1 (1=store, 0=load); req_addr in 32 (byte address); req_wdata in 32 (store data, LSB-aligned); req_size in 2 (00=byte, 01=half, 10=word, 11 treated as word); req_unsigned in 1 (zero-extend load).
REQ-003 The core-side response port SHALL be: resp_valid out 1 (one-cycle completion pulse); resp_rdata out 32 (extended load data, 0 for stores); resp_err out 1 (misaligned abort).
REQ-004 The memory-side port SHALL be: MEM_WE out 1 (word write enable); MEM_A out 32 (word-aligned byte address); MEM_WD out 32 (full write word); MEM_RD in 32 (combinational read word of MEM_A).

Function
REQ-005 The FSM states SHALL be IDLE, LOAD, MERGE, WRITE and RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; the request is accepted on a rising edge with req_valid=1 in IDLE, and all request fields SHALL be registered at acceptance.
REQ-007 Transitions from IDLE SHALL be: load -> LOAD; word store -> WRITE; byte/half store -> MERGE.
REQ-008 MEM_A SHALL equal {addr_q[31:2],2'b00} in LOAD, MERGE and WRITE, and 0 elsewhere.
REQ-009 LOAD SHALL sample MEM_RD, select the lane by addr_q[1:0], sign- or zero-extend per req_unsigned and size, and go to RESP; latency is resp_valid two cycles after acceptance.
REQ-010 MERGE SHALL sample MEM_RD, replace only the addressed byte/half lanes with the low bits of wdata_q, hold the merged word and go to WRITE; the total store latency is three cycles.
REQ-011 WRITE SHALL drive MEM_WE=1 for exactly one cycle with MEM_WD equal to the stored or merged word, then go to RESP; a word store has two-cycle latency.
REQ-012 RESP SHALL drive resp_valid=1 for one cycle and return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-013 MEM_WE SHALL be 0 in every state other than WRITE; stores SHALL be little-endian (byte at addr[1:0]=k occupies bits 8k+7:8k).
REQ-014 resp_rdata SHALL hold its value until the next response; for stores resp_rdata SHALL be 0.

Reset
REQ-015 When RST_N is low the FSM SHALL enter IDLE and resp_valid, resp_rdata, resp_err, MEM_WE, MEM_A and MEM_WD SHALL be 0 asynchronously.
REQ-016 Reset asserted mid-operation SHALL abort the transaction with no MEM_WE pulse and no resp_valid; after release req_ready SHALL be 1.

Configuration
REQ-017 Macro LSU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL skip memory access, go IDLE->RESP, and pulse resp_valid with resp_err=1 and resp_rdata=0 one cycle after acceptance.
REQ-018 Macro undefined: the offending low address bits SHALL be ignored (half uses addr[1], word uses lane 0) and resp_err SHALL be tied to 0.

Structure
REQ-019 Package lsu_pkg SHALL hold the size encodings, the FSM state enumeration and the lane-select constants.
REQ-020 A purely combinational sub-module lsu_lane_align SHALL perform load extract/extend and store merge; all sequencing stays in load_store_unit.

Verification
REQ-021 Memory word 0x40 = 0x8899AABB; lb at 0x41 -> resp_rdata=0xFFFFFFAA two cycles after accept; lbu at 0x41 -> 0x000000AA.
REQ-022 Word 0x40 = 0x8899AABB; sh 0x1234 at 0x42 -> MEM_WE pulse at cycle 2 with MEM_WD=0x1234AABB and MEM_A=0x40, resp_valid at cycle 3.
REQ-023 sw 0xDEADBEEF at 0x80 -> MEM_WE=1 at cycle 1 only, MEM_WD=0xDEADBEEF, resp_valid at cycle 2, resp_rdata=0.
REQ-024 Trap build: lw at 0x82 -> no MEM_WE, resp_valid with resp_err=1 at cycle 1; non-trap build: same request reads word 0x80, resp_err=0.
REQ-025 Assert RST_N low during MERGE of sb at 0x43 -> no MEM_WE pulse, no resp_valid, memory unchanged, req_ready=1 after release.
REQ-026 Back-to-back req_valid held high -> req_ready low outside IDLE, each request accepted exactly once, responses in order.
